// File: rtl/ex_div_unit_pkg.sv
// ex_div_unit_pkg: shared definitions for the EX-stage integer divider.
//   RST_ENABLE        reset-asserted level for rst (active low)
//   ZEROWORD32        32-bit zero word
//   GPR_BUS           general-purpose register width
//   EXE_DIV_OP/DIVU   aluop codes for DIV/DIVU (decoded by the EX top, not by the divider)
//   div_state_e       divider FSM states
package ex_div_unit_pkg;

    localparam logic        RST_ENABLE   = 1'b0;
    localparam logic [31:0] ZEROWORD32   = 32'h0000_0000;
    localparam int          GPR_BUS      = 32;

    localparam logic [7:0]  EXE_DIV_OP   = 8'b0001_1010;
    localparam logic [7:0]  EXE_DIVU_OP  = 8'b0001_1011;

    typedef enum logic [1:0] {
        DivIdle = 2'b00,
        DivBusy = 2'b01,
        DivDone = 2'b10
    } div_state_e;

endpackage

// File: rtl/ex_div_unit_step.sv
// ex_div_unit_step: one combinational restoring-division step.
//   rem_in   in   WIDTH  current partial remainder (always < divisor)
//   bit_in   in   1      next dividend bit shifted into the remainder
//   divisor  in   WIDTH  divisor magnitude (non-zero)
//   rem_out  out  WIDTH  partial remainder after this step
//   q_bit    out  1      quotient bit produced by this step
module ex_div_unit_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH-1:0] shifted_low;
    logic [WIDTH-1:0] diff;

    always_comb begin
        shifted_low = {rem_in[WIDTH-2:0], bit_in};
        // The shifted remainder is WIDTH+1 bits wide; if its top bit (rem_in MSB) is set it
        // already exceeds any WIDTH-bit divisor. The true difference always fits in WIDTH
        // bits, so a modulo-2^WIDTH subtraction of the low bits is exact.
        diff    = shifted_low - divisor;
        q_bit   = rem_in[WIDTH-1] | (shifted_low >= divisor);
        rem_out = q_bit ? diff : shifted_low;
    end

endmodule

// File: rtl/ex_div_unit.sv
// ex_div_unit: multi-cycle integer divider for DIV/DIVU in the EX stage.
//   clk           in   1      clock
//   rst           in   1      asynchronous reset, active low
//   exception     in   1      pipeline flush, synchronous cancel
//   div_start     in   1      DIV/DIVU held in EX
//   div_signed    in   1      1 = DIV, 0 = DIVU
//   dividend      in   WIDTH  rs operand
//   divisor       in   WIDTH  rt operand
//   stall_req     out  1      EX stall request
//   result_valid  out  1      quotient/remainder valid
//   quotient      out  WIDTH  to LO
//   remainder     out  WIDTH  to HI
// Operands are latched as magnitudes on start; one restoring step per BUSY cycle, WIDTH steps,
// then the sign fix is applied while writing the result registers.
module ex_div_unit
    import ex_div_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             exception,
    input  logic             div_start,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             stall_req,
    output logic             result_valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    div_state_e       state;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] acc;      // dividend bits shift out the top, quotient bits shift in
    logic [WIDTH-1:0] dvs;      // divisor magnitude
    logic [WIDTH-1:0] prem;     // partial remainder
    logic             q_neg;
    logic             r_neg;

    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH-1:0] dvd_abs;
    logic [WIDTH-1:0] dvs_abs;

    logic [WIDTH-1:0] step_rem;
    logic             step_q;
    logic [WIDTH-1:0] next_acc;

    always_comb begin
        dvd_neg  = div_signed & dividend[WIDTH-1];
        dvs_neg  = div_signed & divisor[WIDTH-1];
        dvd_abs  = dvd_neg ? (~dividend + 1'b1) : dividend;
        dvs_abs  = dvs_neg ? (~divisor + 1'b1) : divisor;
        next_acc = {acc[WIDTH-2:0], step_q};
    end

    ex_div_unit_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_in  (prem),
        .bit_in  (acc[WIDTH-1]),
        .divisor (dvs),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    // Not gated by exception: a flush cancels on the next edge anyway.
    assign stall_req = div_start & (state != DivDone);

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            state        <= DivIdle;
            count        <= '0;
            acc          <= '0;
            dvs          <= '0;
            prem         <= '0;
            q_neg        <= 1'b0;
            r_neg        <= 1'b0;
            quotient     <= '0;
            remainder    <= '0;
            result_valid <= 1'b0;
        end else if (exception) begin
            state        <= DivIdle;
            count        <= '0;
            result_valid <= 1'b0;
        end else begin
            case (state)
                DivIdle: begin
                    if (div_start) begin
                        acc   <= dvd_abs;
                        dvs   <= dvs_abs;
                        prem  <= '0;
                        q_neg <= dvd_neg ^ dvs_neg;
                        r_neg <= dvd_neg;
                        count <= '0;
                        if (divisor == '0) begin
                            // Divide by zero: no iteration, fixed result pattern.
                            quotient     <= '1;
                            remainder    <= dividend;
                            result_valid <= 1'b1;
                            state        <= DivDone;
                        end else begin
                            state <= DivBusy;
                        end
                    end
                end
                DivBusy: begin
                    acc   <= next_acc;
                    prem  <= step_rem;
                    count <= count + 1'b1;
                    if (count == CNT_W'(WIDTH - 1)) begin
                        // Negating the magnitude 2^(WIDTH-1) wraps to itself, which gives the
                        // most-negative / -1 result without a special case.
                        quotient     <= q_neg ? (~next_acc + 1'b1) : next_acc;
                        remainder    <= r_neg ? (~step_rem + 1'b1) : step_rem;
                        result_valid <= 1'b1;
                        state        <= DivDone;
                    end
                end
                DivDone: begin
                    // ID/EX may be frozen with the same instruction still present; wait for
                    // it to leave rather than re-executing it.
                    if (!div_start) begin
                        result_valid <= 1'b0;
                        state        <= DivIdle;
                    end
                end
                default: begin
                    state        <= DivIdle;
                    result_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_div_unit.sv
module tb_ex_div_unit;

    logic        clk;
    logic        rst;
    logic        exception;
    logic        div_start;
    logic        div_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        stall_req;
    logic        result_valid;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int n_checks = 0;
    int n_errors = 0;

    ex_div_unit #(
        .WIDTH (32),
        .CNT_W (6)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .exception    (exception),
        .div_start    (div_start),
        .div_signed   (div_signed),
        .dividend     (dividend),
        .divisor      (divisor),
        .stall_req    (stall_req),
        .result_valid (result_valid),
        .quotient     (quotient),
        .remainder    (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Architectural result of DIV/DIVU, using the simulator's own arithmetic.
    function automatic void model(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (b == 32'h0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000;
                r = 32'h0;
            end else begin
                q = sa / sb;
                r = sa % sb;
            end
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Counts stall cycles from the current cycle until result_valid, bounded.
    task automatic wait_result(input bit scramble, output int stalls, output bit ok);
        stalls = 0;
        ok     = 1'b0;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (result_valid) begin
                ok = 1'b1;
                break;
            end
            if (stall_req) stalls++;
            @(negedge clk);
            if (scramble) begin
                dividend = $urandom;
                divisor  = $urandom;
            end
        end
    endtask

    task automatic do_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input bit scramble);
        logic [31:0] eq;
        logic [31:0] er;
        int          st;
        bit          ok;
        model(sgn, a, b, eq, er);
        @(negedge clk);
        div_signed = sgn;
        dividend   = a;
        divisor    = b;
        div_start  = 1'b1;
        wait_result(scramble, st, ok);
        check("done_seen", 32'(ok), 32'd1);
        check("stall_cycles", 32'(st), (b == 32'h0) ? 32'd1 : 32'd33);
        check("stall_in_done", 32'(stall_req), 32'd0);
        check("quotient", quotient, eq);
        check("remainder", remainder, er);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            dividend = $urandom;
            #1;
            check("hold_valid", 32'(result_valid), 32'd1);
            check("hold_stall", 32'(stall_req), 32'd0);
            check("hold_quot", quotient, eq);
            check("hold_rem", remainder, er);
        end
        @(negedge clk);
        div_start = 1'b0;
        @(negedge clk);
        #1;
        check("idle_valid", 32'(result_valid), 32'd0);
        check("idle_quot", quotient, eq);
        check("idle_rem", remainder, er);
    endtask

    initial begin
        int          st;
        bit          ok;
        bit          sgn;
        logic [31:0] a;
        logic [31:0] b;
        int          mode;

        rst        = 1'b0;
        exception  = 1'b0;
        div_start  = 1'b0;
        div_signed = 1'b0;
        dividend   = 32'h0;
        divisor    = 32'h0;
        #12;
        check("rst_valid", 32'(result_valid), 32'd0);
        check("rst_stall", 32'(stall_req), 32'd0);
        check("rst_quot", quotient, 32'h0);
        check("rst_rem", remainder, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        do_div(1'b0, 32'd100, 32'd7, 5, 1'b0);
        do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
        do_div(1'b0, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1, 1'b0);
        do_div(1'b0, 32'd5, 32'd0, 2, 1'b0);
        do_div(1'b1, 32'd5, 32'd0, 0, 1'b0);

        // Flush on the 10th BUSY cycle, then a fresh start from IDLE.
        @(negedge clk);
        div_signed = 1'b0;
        dividend   = 32'd1000;
        divisor    = 32'd3;
        div_start  = 1'b1;
        repeat (10) @(negedge clk);
        exception = 1'b1;
        @(negedge clk);
        exception = 1'b0;
        dividend  = 32'd42;
        divisor   = 32'd6;
        #1;
        check("flush_valid", 32'(result_valid), 32'd0);
        wait_result(1'b0, st, ok);
        check("flush_done_seen", 32'(ok), 32'd1);
        check("flush_restart_stall", 32'(st), 32'd33);
        check("flush_quot", quotient, 32'd7);
        check("flush_rem", remainder, 32'd0);
        @(negedge clk);
        div_start = 1'b0;
        @(negedge clk);

        // Async reset between edges mid-BUSY.
        div_signed = 1'b0;
        dividend   = 32'd1000;
        divisor    = 32'd7;
        div_start  = 1'b1;
        repeat (5) @(negedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("async_rst_valid", 32'(result_valid), 32'd0);
        check("async_rst_quot", quotient, 32'h0);
        check("async_rst_rem", remainder, 32'h0);
        @(negedge clk);
        div_start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        do_div(1'b0, 32'd9, 32'd3, 0, 1'b0);

        for (int n = 0; n < 24; n++) begin
            sgn  = 1'($urandom_range(0, 1));
            a    = $urandom;
            mode = $urandom_range(0, 6);
            case (mode)
                0:       b = 32'h0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'($urandom_range(1, 15));
                3:       b = a;
                4:       begin a = 32'($urandom_range(0, 50)); b = $urandom; end
                default: b = $urandom;
            endcase
            do_div(sgn, a, b, $urandom_range(0, 3), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
